multi_clock_divider: RTL and testbench
======================================

Name: multi_clock_divider

Overview:
- Parametrised N-channel clock/tick generator; successor to the single-channel toggle divider.
- Each channel has a runtime divisor, a mode (toggle, single-cycle pulse, programmable duty), an enable and a shadowed reload applied at period boundaries.
- A global sync strobe phase-aligns all channels.
- Feeds LED blinkers, 7-seg scan, UART baud ticks and PWM on the DE0-CV designs. All outputs are registered, clk-domain enables/levels.

Parameters:
- NCH, 4, number of independent channels (1..16).
- CNT_W, 32, counter/divisor/high-count width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- en  in  NCH  per-channel enable (level)
- sync_i  in  1  one-cycle strobe; restarts all enabled channels at count 0
- load  in  NCH  per-channel strobe; capture div_i/high_i/mode_i into the shadow registers
- div_i  in  NCH x CNT_W  requested divisor (packed [NCH-1:0][CNT_W-1:0])
- high_i  in  NCH x CNT_W  requested high count for DUTY mode
- mode_i  in  NCH x 2  requested mode
- clk_out  out  NCH  divided output per channel
- tick  out  NCH  one-cycle pulse at each period wrap
- pend  out  NCH  shadow value captured but not yet active

Behaviour:
- Reset (rst_n low at a clk edge) clears every register: counters 0, active/shadow div, high and mode 0, clk_out 0, tick 0, pend 0.
- Per-channel active set is div_q, high_q and mode_q. Effective divisor D is max(div_q,1): divisor values 0 and 1 both give a one-cycle period.
- Counter runs 0..D-1. A wrap happens at the edge where en=1 and count==D-1: count goes to 0 and tick=1 for exactly the following cycle. Otherwise count increments and tick=0.
- Disabled channel (en=0): count held at 0, clk_out 0, tick 0. On re-enable, the first wrap is registered at the D-th rising edge with en sampled high.
- Mode 0, TOGGLE: clk_out inverts on each wrap, giving period 2*D with 50% duty.
- Mode 1, PULSE: clk_out equals tick.
- Mode 2, DUTY: clk_out=1 while the next count is < high_q, giving period D.
  - high_q=0 holds clk_out low.
  - high_q>=D holds clk_out high.
- Mode 3: reserved; behaves as TOGGLE.
- Reload:
  - load=1 captures the inputs into shadow and sets pend.
  - The shadow set is applied, and pend cleared, at the earliest of: the next wrap, the next sync_i, or any cycle with en=0.
  - On apply, the new D governs the following period. clk_out in TOGGLE mode keeps its level.
  - load on the same cycle as apply: the new inputs are captured and pend stays 1. They are applied at the next opportunity, not the current one.
- sync_i: every enabled channel sets count=0, clk_out=0 and tick=0, and applies any pending shadow. Channels with en=0 are unaffected beyond their disabled behaviour.
- Priority per channel: rst_n > en=0 > sync_i > wrap/apply > increment.
- Counter arithmetic is CNT_W-bit unsigned. Compare against D-1 with no overflow, so div_i = 2^CNT_W-1 is legal.
- Reset mid-operation aborts all periods immediately with no final tick.
- Channels are fully independent apart from sync_i.

Decomposition:
- Package clkdiv_pkg:
  - clkdiv_mode_e enum: TOGGLE=0, PULSE=1, DUTY=2, RSVD=3.
  - Channel config struct {div, high, mode}, parametrised by CNT_W via localparam default 32.
- Sub-module clkdiv_channel holds one channel (counter, shadow, pend, output logic). The top instantiates it NCH times in a generate loop and fans out sync_i.

Test Plan:
- Reset, load div=4 mode=TOGGLE on ch0, en=1 -> clk_out toggles every 4 cycles (period 8); tick pulses at cycles 4, 8, 12 after enable; pend drops after the load is applied while disabled.
- ch1 DUTY, div=10, high=3 -> clk_out high 3 / low 7 repeating. Repeat with high=0 -> always low; high=15 -> always high.
- ch2 PULSE div=5 running; load div=2 at mid-period count 2 -> pend=1 until the wrap at count 4, then ticks every 2 cycles; no short period.
- div=0 and div=1 in PULSE mode -> tick and clk_out constantly 1; TOGGLE mode -> clk_out toggles every cycle.
- Four channels with divs 3, 5, 7, 11, all enabled; pulse sync_i -> all counts 0 and clk_out 0 next cycle; the first ticks occur at 3, 5, 7 and 11 cycles after sync.
- Drive rst_n low for 1 cycle mid-period with load pending -> all outputs 0 and pend 0 next cycle; shadow discarded; restart with divisor 0 behaviour until reloaded.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types for the multi-channel clock/tick divider.
// Mode encoding, default counter width and the per-channel configuration record.
package clkdiv_pkg;

  localparam int unsigned ClkdivCntW = 32;

  typedef enum logic [1:0] {
    TOGGLE = 2'd0,
    PULSE  = 2'd1,
    DUTY   = 2'd2,
    RSVD   = 2'd3
  } clkdiv_mode_e;

  typedef struct packed {
    logic [ClkdivCntW-1:0] div;
    logic [ClkdivCntW-1:0] high;
    clkdiv_mode_e          mode;
  } clkdiv_cfg_t;

  // The reserved encoding runs as a plain toggle divider.
  function automatic logic is_toggle(clkdiv_mode_e mode);
    return (mode == TOGGLE) || (mode == RSVD);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, shadowed reload and registered output shaping.
// The shadow set becomes active at a wrap, a sync strobe or any disabled cycle.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = ClkdivCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_i,
  input  logic             load,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [1:0]       mode_i,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
    clkdiv_mode_e     mode;
  } cfg_t;

  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] eff_div;
  logic             wrap;
  logic             apply;

  // Divisors 0 and 1 both mean a one-cycle period; D-1 never underflows.
  assign eff_div = (act_q.div == '0) ? CNT_W'(1) : act_q.div;
  assign wrap    = (cnt_q == eff_div - CNT_W'(1));
  assign apply   = pend_q && (!en || sync_i || wrap);

  always_comb begin
    act_d     = act_q;
    shd_d     = shd_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    // A load coinciding with an apply is held for the next opportunity.
    if (load) begin
      shd_d.div  = div_i;
      shd_d.high = high_i;
      shd_d.mode = clkdiv_mode_e'(mode_i);
      pend_d     = 1'b1;
    end

    if (!en || sync_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap;
      if (is_toggle(act_d.mode)) begin
        if (wrap) clk_out_d = ~clk_out_q;
      end else if (act_d.mode == PULSE) begin
        clk_out_d = wrap;
      end else begin
        clk_out_d = (cnt_d < act_d.high);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q     <= '0;
      shd_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N independent divider channels sharing a common phase-alignment strobe.
// All outputs are registered inside the channels.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = ClkdivCntW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            en,
  input  logic                      sync_i,
  input  logic [NCH-1:0]            load,
  input  logic [NCH-1:0][CNT_W-1:0] div_i,
  input  logic [NCH-1:0][CNT_W-1:0] high_i,
  input  logic [NCH-1:0][1:0]       mode_i,
  output logic [NCH-1:0]            clk_out,
  output logic [NCH-1:0]            tick,
  output logic [NCH-1:0]            pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync_i  (sync_i),
      .load    (load[g]),
      .div_i   (div_i[g]),
      .high_i  (high_i[g]),
      .mode_i  (mode_i[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed scenarios plus randomized traffic for multi_clock_divider against a
// per-channel period/phase model; every output is compared after each clock.
module tb_multi_clock_divider;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NCH-1:0]            en;
  logic                      sync_i;
  logic [NCH-1:0]            load;
  logic [NCH-1:0][CNT_W-1:0] div_i;
  logic [NCH-1:0][CNT_W-1:0] high_i;
  logic [NCH-1:0][1:0]       mode_i;
  logic [NCH-1:0]            clk_out;
  logic [NCH-1:0]            tick;
  logic [NCH-1:0]            pend;

  always #5 clk = ~clk;

  multi_clock_divider #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_i  (sync_i),
    .load    (load),
    .div_i   (div_i),
    .high_i  (high_i),
    .mode_i  (mode_i),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: phase within the current period plus active/shadow settings.
  longint unsigned m_phase [NCH];
  longint unsigned a_div   [NCH];
  longint unsigned a_high  [NCH];
  int unsigned     a_mode  [NCH];
  longint unsigned s_div   [NCH];
  longint unsigned s_high  [NCH];
  int unsigned     s_mode  [NCH];
  bit              m_pend  [NCH];
  bit              m_clk   [NCH];
  bit              m_tick  [NCH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      longint unsigned period;
      bit              last;
      bit              take;
      if (!rst_n) begin
        m_phase[ch] = 0; a_div[ch] = 0; a_high[ch] = 0; a_mode[ch] = 0;
        s_div[ch] = 0; s_high[ch] = 0; s_mode[ch] = 0;
        m_pend[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
      end else begin
        period = (a_div[ch] < 2) ? 1 : a_div[ch];
        last   = (m_phase[ch] + 1 == period);
        take   = m_pend[ch] && (!en[ch] || sync_i || last);
        if (take) begin
          a_div[ch] = s_div[ch]; a_high[ch] = s_high[ch]; a_mode[ch] = s_mode[ch];
          m_pend[ch] = 0;
        end
        if (load[ch]) begin
          s_div[ch] = div_i[ch]; s_high[ch] = high_i[ch]; s_mode[ch] = mode_i[ch];
          m_pend[ch] = 1;
        end
        m_tick[ch] = 0;
        if (!en[ch] || sync_i) begin
          m_phase[ch] = 0;
          m_clk[ch]   = 0;
        end else begin
          m_tick[ch]  = last;
          m_phase[ch] = last ? 0 : m_phase[ch] + 1;
          case (a_mode[ch])
            1:       m_clk[ch] = last;
            2:       m_clk[ch] = (m_phase[ch] < a_high[ch]);
            default: if (last) m_clk[ch] = !m_clk[ch];
          endcase
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      check_eq($sformatf("model clk_out[%0d]", ch), 64'(clk_out[ch]), 64'(m_clk[ch]));
      check_eq($sformatf("model tick[%0d]", ch), 64'(tick[ch]), 64'(m_tick[ch]));
      check_eq($sformatf("model pend[%0d]", ch), 64'(pend[ch]), 64'(m_pend[ch]));
    end
  endtask

  task automatic clear_inputs();
    en = '0; load = '0; sync_i = 1'b0;
    div_i = '0; high_i = '0; mode_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Load one channel while disabled and let the disabled cycle apply it.
  task automatic preload(input int ch, input logic [31:0] d, input logic [31:0] h,
                         input logic [1:0] m);
    load[ch] = 1'b1; div_i[ch] = d; high_i[ch] = h; mode_i[ch] = m;
    step();
    load[ch] = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    int sync_div [NCH];
    logic [31:0] duty_high [3];
    int          duty_exp  [3];

    rst_n = 1'b0;
    clear_inputs();
    do_reset();
    check_eq("reset clk_out", 64'(clk_out), 64'(0));
    check_eq("reset tick", 64'(tick), 64'(0));
    check_eq("reset pend", 64'(pend), 64'(0));

    // Toggle divider, divisor 4.
    preload(0, 4, 0, 2'd0);
    check_eq("t1 pend set", 64'(pend[0]), 64'(1));
    step();
    check_eq("t1 pend applied while disabled", 64'(pend[0]), 64'(0));
    en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq($sformatf("t1 tick k=%0d", k), 64'(tick[0]), 64'((k % 4) == 0));
      check_eq($sformatf("t1 clk k=%0d", k), 64'(clk_out[0]), 64'((k / 4) % 2));
    end

    // Duty mode, divisor 10 with several high counts.
    duty_high = '{32'd3, 32'd0, 32'd15};
    duty_exp  = '{6, 0, 20};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      preload(1, 10, duty_high[i], 2'd2);
      step();
      en[1] = 1'b1;
      hi_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
        step();
        hi_cnt += int'(clk_out[1]);
        if (i == 0)
          check_eq($sformatf("t2 duty k=%0d", k), 64'(clk_out[1]), 64'((k % 10) < 3));
      end
      check_eq($sformatf("t2 high samples h=%0d", duty_high[i]), 64'(hi_cnt),
               64'(duty_exp[i]));
    end

    // Pulse divisor 5, reload to 2 mid-period: no short period.
    do_reset();
    preload(2, 5, 0, 2'd1);
    step();
    en[2] = 1'b1;
    step();
    step();
    load[2] = 1'b1; div_i[2] = 2; mode_i[2] = 2'd1;
    for (int k = 3; k <= 9; k++) begin
      step();
      load[2] = 1'b0;
      check_eq($sformatf("t3 pend k=%0d", k), 64'(pend[2]), 64'(k < 5));
      check_eq($sformatf("t3 tick k=%0d", k), 64'(tick[2]), 64'((k >= 5) && ((k - 5) % 2 == 0)));
    end

    // Divisors 0 and 1 in pulse and toggle modes.
    do_reset();
    preload(0, 0, 0, 2'd1);
    preload(1, 1, 0, 2'd1);
    preload(2, 0, 0, 2'd0);
    preload(3, 1, 0, 2'd3);
    step();
    en = '1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq($sformatf("t4 tick k=%0d", k), 64'(tick), 64'(4'hF));
      check_eq($sformatf("t4 pulse clk k=%0d", k), 64'(clk_out[1:0]), 64'(2'b11));
      check_eq($sformatf("t4 toggle clk k=%0d", k), 64'(clk_out[3:2]),
               (k % 2) ? 64'(2'b11) : 64'(2'b00));
    end

    // Sync strobe phase-aligns channels with divisors 3, 5, 7, 11.
    do_reset();
    sync_div = '{3, 5, 7, 11};
    for (int ch = 0; ch < NCH; ch++) preload(ch, 32'(sync_div[ch]), 0, 2'd1);
    step();
    en = '1;
    for (int k = 0; k < int'($urandom_range(1, 20)); k++) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check_eq("t5 sync clk_out", 64'(clk_out), 64'(0));
    check_eq("t5 sync tick", 64'(tick), 64'(0));
    for (int k = 1; k <= 11; k++) begin
      step();
      for (int ch = 0; ch < NCH; ch++)
        check_eq($sformatf("t5 tick[%0d] k=%0d", ch, k), 64'(tick[ch]),
                 64'((k % sync_div[ch]) == 0));
    end

    // Reset mid-period with a pending reload discards everything.
    do_reset();
    preload(0, 6, 0, 2'd0);
    step();
    en[0] = 1'b1;
    step(); step(); step();
    load[0] = 1'b1; div_i[0] = 3;
    step();
    load[0] = 1'b0;
    check_eq("t6 pend before reset", 64'(pend[0]), 64'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("t6 reset clk_out", 64'(clk_out), 64'(0));
    check_eq("t6 reset tick", 64'(tick), 64'(0));
    check_eq("t6 reset pend", 64'(pend), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("t6 div0 tick k=%0d", k), 64'(tick[0]), 64'(1));
    end

    // Randomized traffic, including near-full-scale divisors.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      sync_i = ($urandom_range(0, 39) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        int r;
        en[ch]     = ($urandom_range(0, 9) != 0);
        load[ch]   = ($urandom_range(0, 11) == 0);
        r          = int'($urandom_range(0, 19));
        div_i[ch]  = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'hFFFF_FFFE : $urandom_range(0, 12);
        high_i[ch] = $urandom_range(0, 14);
        mode_i[ch] = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
